// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the packet-level UART transmit arbiter.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        StArb      = 3'd0,
        StLoad     = 3'd1,
        StWaitIdle = 3'd2,
        StSend     = 3'd3,
        StWaitDone = 3'd4
    } arb_state_e;

    localparam int unsigned ByteW              = 8;
    localparam int unsigned DefaultSendTimeout = 1023;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams plus the UART transmit handshake, grouped as one bundle.
interface uart_tx_arbiter_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0]   ipReqValid;
    logic [8*N-1:0] ipReqData;
    logic [N-1:0]   ipReqLast;
    logic [N-1:0]   opReqReady;
    logic [N-1:0]   opGrant;
    logic [7:0]     opTxData;
    logic           opTxSend;
    logic           ipTxBusy;
    logic           opTimeout;

    // Arbiter side.
    modport master (
        input  ipReqValid,
        input  ipReqData,
        input  ipReqLast,
        input  ipTxBusy,
        output opReqReady,
        output opGrant,
        output opTxData,
        output opTxSend,
        output opTimeout
    );

    // Requesters and UART transmitter side.
    modport slave (
        output ipReqValid,
        output ipReqData,
        output ipReqLast,
        output ipTxBusy,
        input  opReqReady,
        input  opGrant,
        input  opTxData,
        input  opTxSend,
        input  opTimeout
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request found searching upward (with wrap)
// from the index after the last granted one.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last_idx,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] idx,
    output logic            any
);

    logic [IdxW-1:0] cand;

    // Walk from farthest to nearest so the nearest valid request is the final winner.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int k = int'(N); k >= 1; k--) begin
            cand = IdxW'((int'(last_idx) + k) % int'(N));
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N byte-stream requesters; a granted requester
// keeps the transmitter until its last byte has been sent.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned SendTimeout = DefaultSendTimeout
) (
    input logic               ipClk,
    input logic               ipReset,
    uart_tx_arbiter_if.master bus
);

    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned CntW = $clog2(SendTimeout + 1);

    arb_state_e state_q, state_d;

    logic [N-1:0]       grant_q;
    logic [IdxW-1:0]    gidx_q;
    logic [IdxW-1:0]    last_idx_q;
    logic [ByteW-1:0]   data_q;
    logic               last_flag_q;
    logic [CntW-1:0]    cnt_q;
    logic               timeout_q;

    logic [N-1:0]       rr_grant;
    logic [IdxW-1:0]    rr_idx;
    logic               rr_any;

    logic               accept;
    logic               cnt_hit;
    logic               send_timeout;
    logic               byte_done;
    logic [ByteW-1:0]   sel_data;
    logic               sel_last;

    rr_arbiter #(
        .N    (N),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req      (bus.ipReqValid),
        .last_idx (last_idx_q),
        .grant    (rr_grant),
        .idx      (rr_idx),
        .any      (rr_any)
    );

    assign sel_data     = bus.ipReqData[{gidx_q, 3'b000} +: ByteW];
    assign sel_last     = bus.ipReqLast[gidx_q];
    assign accept       = (state_q == StLoad) && bus.ipReqValid[gidx_q];
    assign cnt_hit      = (cnt_q == CntW'(SendTimeout - 1));
    assign send_timeout = (state_q == StSend) && !bus.ipTxBusy && cnt_hit;
    assign byte_done    = (state_q == StWaitDone) && !bus.ipTxBusy;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q <= StArb;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArb: begin
                if (rr_any) state_d = StLoad;
            end
            StLoad: begin
                if (accept) state_d = StWaitIdle;
            end
            StWaitIdle: begin
                if (!bus.ipTxBusy) state_d = StSend;
            end
            StSend: begin
                // Busy rising takes priority over a timeout landing on the same cycle.
                if (bus.ipTxBusy) begin
                    state_d = StWaitDone;
                end else if (cnt_hit) begin
                    state_d = StWaitIdle;
                end
            end
            StWaitDone: begin
                if (!bus.ipTxBusy) state_d = last_flag_q ? StArb : StLoad;
            end
            default: state_d = StArb;
        endcase
    end

    always_comb begin
        bus.opReqReady = '0;
        bus.opTxSend   = 1'b0;
        if (state_q == StLoad) bus.opReqReady = bus.ipReqValid & grant_q;
        if (state_q == StSend) bus.opTxSend = 1'b1;
    end

    // Grant, byte latch and send-timeout counter.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            grant_q     <= '0;
            gidx_q      <= '0;
            last_idx_q  <= IdxW'(N - 1);
            data_q      <= '0;
            last_flag_q <= 1'b0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= send_timeout;
            if ((state_q == StArb) && rr_any) begin
                grant_q <= rr_grant;
                gidx_q  <= rr_idx;
            end
            if (byte_done && last_flag_q) begin
                grant_q    <= '0;
                last_idx_q <= gidx_q;
            end
            if (accept) begin
                data_q      <= sel_data;
                last_flag_q <= sel_last;
            end
            cnt_q <= (state_q == StSend) ? cnt_q + 1'b1 : '0;
        end
    end

    assign bus.opGrant   = grant_q;
    assign bus.opTxData  = data_q;
    assign bus.opTimeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: queued requester packets, a behavioural UART busy model and a
// round-robin packet-order reference model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TOUT = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(NREQ)) bus ();

    uart_tx_arbiter #(
        .N           (NREQ),
        .SendTimeout (TOUT)
    ) dut (
        .ipClk   (clk),
        .ipReset (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Per-requester byte queues (fixed arrays with head/tail).
    logic [7:0] pd [NREQ][64];
    logic       pl [NREQ][64];
    int         head [NREQ];
    int         tail [NREQ];
    bit         drv_en = 1'b0;
    bit         gap_en = 1'b0;

    int         acc_idx [$];
    logic [7:0] acc_dat [$];
    logic [7:0] snd_dat [$];

    bit never_busy = 1'b0;
    bit force_busy = 1'b0;
    bit rand_busy  = 1'b0;
    int busy_len   = 8;
    int busy_cnt   = 0;

    // Requester driver: owner may drop valid mid-packet; others hold it while queued.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (drv_en && head[i] < tail[i]) begin
                bus.ipReqValid[i]       = (bus.opGrant[i] && gap_en) ? ($urandom_range(0, 3) != 0)
                                                                     : 1'b1;
                bus.ipReqData[8*i +: 8] = pd[i][head[i]];
                bus.ipReqLast[i]        = pl[i][head[i]];
            end else begin
                bus.ipReqValid[i]       = 1'b0;
                bus.ipReqData[8*i +: 8] = 8'($urandom);
                bus.ipReqLast[i]        = 1'b0;
            end
        end
        #1;
        if (bus.opReqReady != '0) begin
            total++;
            if (bus.opReqReady !== (bus.ipReqValid & bus.opGrant) || !$onehot(bus.opReqReady)) begin
                bad++;
                $display("FAIL ready_gate: ready=%b valid=%b grant=%b", bus.opReqReady,
                         bus.ipReqValid, bus.opGrant);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ipReqValid[i] && bus.opReqReady[i]) begin
                acc_idx.push_back(i);
                acc_dat.push_back(pd[i][head[i]]);
                head[i]++;
            end
        end
    end

    // UART transmitter model: answers a send with a busy period.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else if (!never_busy && bus.opTxSend && busy_cnt == 0) begin
            busy_cnt = rand_busy ? int'($urandom_range(1, 12)) : busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        bus.ipTxBusy = force_busy || (busy_cnt > 0);
    end

    // Send monitor: log each send pulse and require stable data while send is high.
    logic       prev_send = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (bus.opTxSend && !prev_send) snd_dat.push_back(bus.opTxData);
        if (bus.opTxSend && prev_send) begin
            total++;
            if (bus.opTxData !== prev_data) begin
                bad++;
                $display("FAIL data_stable: got %h, held %h", bus.opTxData, prev_data);
            end
        end
        prev_send = bus.opTxSend;
        prev_data = bus.opTxData;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_queues();
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        acc_idx.delete();
        acc_dat.delete();
        snd_dat.delete();
    endtask

    task automatic do_reset();
        drv_en     = 1'b0;
        gap_en     = 1'b0;
        never_busy = 1'b0;
        force_busy = 1'b0;
        rand_busy  = 1'b0;
        busy_len   = 8;
        clear_queues();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        pd[r][tail[r]] = d;
        pl[r][tail[r]] = l;
        tail[r]++;
    endtask

    task automatic wait_drain(input int limit, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (all_empty() && bus.opGrant == '0 && !bus.opTxSend && !bus.ipTxBusy) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_drain: not idle after %0d cycles, grant=%b", name, limit, bus.opGrant);
        end
    endtask

    task automatic wait_send(input int limit, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (bus.opTxSend) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_send: opTxSend never rose within %0d cycles", name, limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total += 5;
        if (bus.opGrant !== '0) begin bad++; $display("FAIL rst_grant: got %b want 0", bus.opGrant); end
        if (bus.opReqReady !== '0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.opReqReady); end
        if (bus.opTxData !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", bus.opTxData); end
        if (bus.opTxSend !== 1'b0) begin bad++; $display("FAIL rst_send: got %b want 0", bus.opTxSend); end
        if (bus.opTimeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", bus.opTimeout); end
        rst = 1'b0;
    endtask

    task automatic test_single_byte();
        bit seen = 1'b0;
        do_reset();
        busy_len = 4340;
        push_byte(2, 8'hA5, 1'b1);
        drv_en = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = (bus.opGrant != '0);
        end
        total++;
        if (bus.opGrant !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", bus.opGrant); end
        @(negedge clk);
        total++;
        if (bus.opTxSend !== 1'b0) begin bad++; $display("FAIL single_send_early: got %b want 0", bus.opTxSend); end
        @(negedge clk);
        total++;
        if (bus.opTxSend !== 1'b1) begin bad++; $display("FAIL single_send_latency: got %b want 1", bus.opTxSend); end
        wait_drain(6000, "single");
        total += 4;
        if (snd_dat.size() != 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", snd_dat.size()); end
        else if (snd_dat[0] !== 8'hA5) begin bad++; $display("FAIL single_sent: got %h want a5", snd_dat[0]); end
        if (bus.opTxData !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", bus.opTxData); end
        if (bus.opGrant !== '0) begin bad++; $display("FAIL single_release: got %b want 0", bus.opGrant); end
        if (acc_idx.size() != 1) begin bad++; $display("FAIL single_accepts: got %0d want 1", acc_idx.size()); end
    endtask

    task automatic test_round_robin();
        int         want_i [4] = '{0, 1, 3, 0};
        logic [7:0] want_d [4] = '{8'h10, 8'h20, 8'h40, 8'h50};
        do_reset();
        busy_len = 6;
        push_byte(0, 8'h10, 1'b1);
        push_byte(0, 8'h50, 1'b1);
        push_byte(1, 8'h20, 1'b1);
        push_byte(3, 8'h40, 1'b1);
        drv_en = 1'b1;
        wait_drain(400, "rr");
        total++;
        if (acc_idx.size() != 4) begin
            bad++;
            $display("FAIL rr_count: got %0d want 4", acc_idx.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (acc_idx[k] != want_i[k] || acc_dat[k] !== want_d[k]) begin
                    bad++;
                    $display("FAIL rr_order[%0d]: got req%0d/%h want req%0d/%h", k, acc_idx[k],
                             acc_dat[k], want_i[k], want_d[k]);
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        int         want_i [4] = '{1, 1, 1, 0};
        logic [7:0] want_d [4] = '{8'h11, 8'h22, 8'h33, 8'h99};
        bit seen = 1'b0;
        do_reset();
        gap_en   = 1'b1;
        busy_len = 5;
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h33, 1'b1);
        drv_en = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = (bus.opGrant == 4'b0010);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL lock_grant: got %b want 0010", bus.opGrant); end
        push_byte(0, 8'h99, 1'b1);
        wait_drain(600, "lock");
        total++;
        if (acc_idx.size() != 4) begin
            bad++;
            $display("FAIL lock_count: got %0d want 4", acc_idx.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (acc_idx[k] != want_i[k] || acc_dat[k] !== want_d[k]) begin
                    bad++;
                    $display("FAIL lock_order[%0d]: got req%0d/%h want req%0d/%h", k, acc_idx[k],
                             acc_dat[k], want_i[k], want_d[k]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int hc    = 0;
        int guard = 0;
        do_reset();
        never_busy = 1'b1;
        push_byte(0, 8'h5C, 1'b1);
        drv_en = 1'b1;
        wait_send(20, "to");
        while (!bus.opTimeout && guard < 3000) begin
            if (bus.opTxSend) hc++;
            @(negedge clk);
            guard++;
        end
        total += 4;
        if (!bus.opTimeout) begin bad++; $display("FAIL to_pulse: no opTimeout within 3000 cycles"); end
        if (hc != TOUT) begin bad++; $display("FAIL to_cycles: send high %0d cycles want %0d", hc, TOUT); end
        if (bus.opTxSend !== 1'b0) begin bad++; $display("FAIL to_send_drop: got %b want 0", bus.opTxSend); end
        if (bus.opTxData !== 8'h5C) begin bad++; $display("FAIL to_data: got %h want 5c", bus.opTxData); end
        @(negedge clk);
        total += 3;
        if (bus.opTimeout !== 1'b0) begin bad++; $display("FAIL to_width: got %b want 0", bus.opTimeout); end
        if (bus.opTxSend !== 1'b1) begin bad++; $display("FAIL to_retry: got %b want 1", bus.opTxSend); end
        if (bus.opTxData !== 8'h5C) begin bad++; $display("FAIL to_retry_data: got %h want 5c", bus.opTxData); end
        never_busy = 1'b0;
        wait_drain(100, "to");
        total += 2;
        if (acc_idx.size() != 1) begin bad++; $display("FAIL to_accepts: got %0d want 1", acc_idx.size()); end
        if (snd_dat.size() != 2) begin bad++; $display("FAIL to_pulses: got %0d want 2", snd_dat.size()); end
    endtask

    task automatic test_reset_mid_send();
        int sends = 0;
        do_reset();
        never_busy = 1'b1;
        push_byte(1, 8'h31, 1'b0);
        push_byte(1, 8'h32, 1'b1);
        drv_en = 1'b1;
        wait_send(20, "rms");
        repeat (5) @(negedge clk);
        rst    = 1'b1;
        drv_en = 1'b0;
        clear_queues();
        @(negedge clk);
        total += 5;
        if (bus.opGrant !== '0) begin bad++; $display("FAIL rms_grant: got %b want 0", bus.opGrant); end
        if (bus.opReqReady !== '0) begin bad++; $display("FAIL rms_ready: got %b want 0", bus.opReqReady); end
        if (bus.opTxData !== 8'h00) begin bad++; $display("FAIL rms_data: got %h want 00", bus.opTxData); end
        if (bus.opTxSend !== 1'b0) begin bad++; $display("FAIL rms_send: got %b want 0", bus.opTxSend); end
        if (bus.opTimeout !== 1'b0) begin bad++; $display("FAIL rms_timeout: got %b want 0", bus.opTimeout); end
        rst        = 1'b0;
        never_busy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.opTxSend) sends++;
        end
        total++;
        if (sends != 0) begin bad++; $display("FAIL rms_no_retry: send high %0d cycles want 0", sends); end
        push_byte(3, 8'h3A, 1'b1);
        push_byte(0, 8'h0A, 1'b1);
        drv_en = 1'b1;
        wait_drain(200, "rms");
        total++;
        if (acc_idx.size() != 2 || acc_idx[0] != 0 || acc_idx[1] != 3) begin
            bad++;
            $display("FAIL rms_priority: got %0d accepts, first req%0d want req0 then req3",
                     acc_idx.size(), (acc_idx.size() > 0) ? acc_idx[0] : -1);
        end
    endtask

    task automatic test_busy_at_start();
        int  sends = 0;
        bit  got   = 1'b0;
        do_reset();
        force_busy = 1'b1;
        push_byte(2, 8'h7E, 1'b1);
        drv_en = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = (acc_idx.size() == 1);
        end
        total++;
        if (!got) begin bad++; $display("FAIL bas_accept: got %0d accepts want 1", acc_idx.size()); end
        repeat (20) begin
            @(negedge clk);
            if (bus.opTxSend) sends++;
        end
        total += 2;
        if (sends != 0) begin bad++; $display("FAIL bas_hold: send high %0d cycles want 0", sends); end
        if (bus.opGrant !== 4'b0100) begin bad++; $display("FAIL bas_owner: got %b want 0100", bus.opGrant); end
        force_busy = 1'b0;
        wait_send(10, "bas");
        total++;
        if (bus.opTxData !== 8'h7E) begin bad++; $display("FAIL bas_data: got %h want 7e", bus.opTxData); end
        wait_drain(100, "bas");
        total++;
        if (snd_dat.size() != 1) begin bad++; $display("FAIL bas_pulses: got %0d want 1", snd_dat.size()); end
    endtask

    task automatic test_random();
        int         exp_idx [$];
        logic [7:0] exp_dat [$];
        int         mh [NREQ];
        int         last_r = NREQ - 1;
        int         pick;
        int         r;
        int         npk;
        int         nb;
        do_reset();
        gap_en    = 1'b1;
        rand_busy = 1'b1;
        for (int q = 0; q < NREQ; q++) begin
            npk = int'($urandom_range(0, 3));
            for (int p = 0; p < npk; p++) begin
                nb = int'($urandom_range(1, 3));
                for (int b = 0; b < nb; b++) push_byte(q, 8'($urandom), b == nb - 1);
            end
            mh[q] = 0;
        end
        // Reference: whole packets, nearest pending requester after the previous owner.
        forever begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
                r = (last_r + k) % NREQ;
                if (pick < 0 && mh[r] < tail[r]) pick = r;
            end
            if (pick < 0) break;
            do begin
                exp_idx.push_back(pick);
                exp_dat.push_back(pd[pick][mh[pick]]);
                mh[pick]++;
            end while (!pl[pick][mh[pick] - 1]);
            last_r = pick;
        end
        drv_en = 1'b1;
        wait_drain(3000, "rand");
        total += 2;
        if (acc_idx.size() != exp_idx.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d accepts want %0d", acc_idx.size(), exp_idx.size());
        end
        if (snd_dat.size() != exp_dat.size()) begin
            bad++;
            $display("FAIL rand_pulses: got %0d sends want %0d", snd_dat.size(), exp_dat.size());
        end
        for (int k = 0; k < exp_idx.size() && k < acc_idx.size() && k < snd_dat.size(); k++) begin
            total++;
            if (acc_idx[k] != exp_idx[k] || acc_dat[k] !== exp_dat[k] || snd_dat[k] !== exp_dat[k]) begin
                bad++;
                $display("FAIL rand_byte[%0d]: got req%0d/%h sent %h want req%0d/%h", k, acc_idx[k],
                         acc_dat[k], snd_dat[k], exp_idx[k], exp_dat[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_timeout();
        test_reset_mid_send();
        test_busy_at_start();
        repeat (3) test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
